// File: rtl/ar_router.sv
`default_nettype none
// ============================================================================
//  Module   : ar_router
//  Purpose  : Registered AXI read-address router. One master AR channel is
//             decoded against a base/mask map and forwarded through a
//             one-entry hold register to one of NUM_SLAVES slave AR channels.
//             The last slave is the default (decode-error) target. Reads are
//             counted until their RLAST beat retires them. A change of target
//             slave waits until every earlier read has retired, so R-channel
//             ordering holds for any ID.
//  Ports    : ACLK, ARESETn          clock, async active-low reset
//             m_AR*                  master AR channel (fields, valid/ready)
//             s_AR*                  packed per-slave AR channels, slice k
//             m_RVALID/RREADY/RLAST  master R beat monitor
//             r_sel                  slave owning the outstanding reads
//             rd_outstanding         accepted but not yet retired reads
//  Revision : 1.0 - initial release
// ============================================================================
module ar_router #(
    parameter int ID_width        = 6,
    parameter int ADDR_width      = 32,
    parameter int NUM_SLAVES      = 6,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [(NUM_SLAVES-1)*ADDR_width-1:0] SLV_BASE =
        {32'h0002_0000, 32'h1A10_0000, 32'h0010_0000, 32'h0008_0000, 32'h0000_0000},
    parameter logic [(NUM_SLAVES-1)*ADDR_width-1:0] SLV_MASK =
        {32'hFFFF_F000, 32'hFFFE_0000, 32'hFFFF_8000, 32'hFFFF_FE00, 32'hFFFF_8000}
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic [ID_width-1:0]                m_ARID,
    input  logic [ADDR_width-1:0]              m_ARADDR,
    input  logic [7:0]                         m_ARLEN,
    input  logic [2:0]                         m_ARSIZE,
    input  logic [1:0]                         m_ARBURST,
    input  logic [3:0]                         m_ARCACHE,
    input  logic [1:0]                         m_ARLOCK,
    input  logic [2:0]                         m_ARPROT,
    input  logic [3:0]                         m_ARQOS,
    input  logic [3:0]                         m_ARREGION,
    input  logic                               m_ARUSER,
    input  logic                               m_ARVALID,
    output logic                               m_ARREADY,
    output logic [NUM_SLAVES*ID_width-1:0]     s_ARID,
    output logic [NUM_SLAVES*ADDR_width-1:0]   s_ARADDR,
    output logic [NUM_SLAVES*8-1:0]            s_ARLEN,
    output logic [NUM_SLAVES*3-1:0]            s_ARSIZE,
    output logic [NUM_SLAVES*2-1:0]            s_ARBURST,
    output logic [NUM_SLAVES*4-1:0]            s_ARCACHE,
    output logic [NUM_SLAVES*2-1:0]            s_ARLOCK,
    output logic [NUM_SLAVES*3-1:0]            s_ARPROT,
    output logic [NUM_SLAVES*4-1:0]            s_ARQOS,
    output logic [NUM_SLAVES*4-1:0]            s_ARREGION,
    output logic [NUM_SLAVES-1:0]              s_ARUSER,
    output logic [NUM_SLAVES-1:0]              s_ARVALID,
    input  logic [NUM_SLAVES-1:0]              s_ARREADY,
    input  logic                               m_RVALID,
    input  logic                               m_RREADY,
    input  logic                               m_RLAST,
    output logic [$clog2(NUM_SLAVES)-1:0]      r_sel,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding
);

    localparam int c_SEL_W = $clog2(NUM_SLAVES);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // Held request. r_tgt serves both as the hold-register slave select and
    // as r_sel: both load the decoded target on accept and nothing else
    // changes either, so a single register carries both.
    logic                  r_hold_v;
    logic [c_SEL_W-1:0]    r_tgt;
    logic [ID_width-1:0]   r_id;
    logic [ADDR_width-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [3:0]            r_cache;
    logic [1:0]            r_lock;
    logic [2:0]            r_prot;
    logic [3:0]            r_qos;
    logic [3:0]            r_region;
    logic                  r_user;
    logic [c_CNT_W-1:0]    r_cnt;
    // Keeps m_ARREADY low while in reset and for the release cycle.
    logic                  r_run;

    logic [c_SEL_W-1:0]    w_dec_sel;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_slv_hs;
    logic                  w_retire;

    // Address decode: scan from the highest region down so the lowest
    // matching index is the one left standing.
    always_comb begin
        w_dec_sel = c_SEL_W'(NUM_SLAVES - 1);
        for (int k = NUM_SLAVES - 2; k >= 0; k--) begin
            if ((m_ARADDR & SLV_MASK[k*ADDR_width +: ADDR_width]) ==
                SLV_BASE[k*ADDR_width +: ADDR_width]) begin
                w_dec_sel = c_SEL_W'(k);
            end
        end
    end

    // Stall uses the registered count, so a new-target request can only be
    // taken on the cycle after the final retire.
    assign w_stall   = (r_cnt == c_CNT_MAX) || ((r_cnt != '0) && (w_dec_sel != r_tgt));
    assign w_slv_hs  = r_hold_v && s_ARREADY[r_tgt];
    assign m_ARREADY = r_run && !w_stall && (!r_hold_v || s_ARREADY[r_tgt]);
    assign w_accept  = m_ARVALID && m_ARREADY;
    // A retire with nothing outstanding is ignored to prevent underflow.
    assign w_retire  = m_RVALID && m_RREADY && m_RLAST && (r_cnt != '0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_run    <= 1'b0;
            r_hold_v <= 1'b0;
            r_tgt    <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cache  <= '0;
            r_lock   <= '0;
            r_prot   <= '0;
            r_qos    <= '0;
            r_region <= '0;
            r_user   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_hold_v <= 1'b1;
                r_tgt    <= w_dec_sel;
                {r_id, r_addr, r_len, r_size, r_burst, r_cache,
                 r_lock, r_prot, r_qos, r_region, r_user} <=
                {m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARCACHE,
                 m_ARLOCK, m_ARPROT, m_ARQOS, m_ARREGION, m_ARUSER};
            end else if (w_slv_hs) begin
                r_hold_v <= 1'b0;
            end

            if (w_accept && !w_retire) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (!w_accept && w_retire) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    // Only the selected slice carries the held request; every other slice
    // is driven to zero.
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slv
        logic w_slot;
        assign w_slot = (r_tgt == c_SEL_W'(k));

        assign s_ARVALID[k]                        = w_slot && r_hold_v;
        assign s_ARID[k*ID_width +: ID_width]      = w_slot ? r_id     : '0;
        assign s_ARADDR[k*ADDR_width +: ADDR_width] = w_slot ? r_addr  : '0;
        assign s_ARLEN[k*8 +: 8]                   = w_slot ? r_len    : '0;
        assign s_ARSIZE[k*3 +: 3]                  = w_slot ? r_size   : '0;
        assign s_ARBURST[k*2 +: 2]                 = w_slot ? r_burst  : '0;
        assign s_ARCACHE[k*4 +: 4]                 = w_slot ? r_cache  : '0;
        assign s_ARLOCK[k*2 +: 2]                  = w_slot ? r_lock   : '0;
        assign s_ARPROT[k*3 +: 3]                  = w_slot ? r_prot   : '0;
        assign s_ARQOS[k*4 +: 4]                   = w_slot ? r_qos    : '0;
        assign s_ARREGION[k*4 +: 4]                = w_slot ? r_region : '0;
        assign s_ARUSER[k]                         = w_slot && r_user;
    end

    assign r_sel          = r_tgt;
    assign rd_outstanding = r_cnt;

endmodule
`default_nettype wire
